// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register (main + skid) with valid/ready handshake and flush.
// Latency: an entry accepted into an empty stage (or with a simultaneous consume) is on out_* one falling edge later.
// Backpressure: in_ready drops only when both registers are held; it never looks at out_ready, so ready is not combinational end to end.
// Ports:
//   clk        - single clock, state updates on the falling edge
//   Reset      - asynchronous active-high reset, discards everything
//   Bubble     - synchronous flush, priority over accept/consume
//   in_valid / in_ready / in_ctrl / in_data    - upstream handshake and fields
//   out_valid / out_ready / out_ctrl / out_data - downstream handshake and registered fields
//   occupancy  - held entry count (0..2)
module pipe_stage_reg #(
  parameter int unsigned           CTRL_W      = 16,
  parameter int unsigned           DATA_W      = 117,
  parameter logic [CTRL_W-1:0]     BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   r_skid_data;

  state_t              w_state_nxt;
  logic [CTRL_W-1:0]   w_main_ctrl_nxt;
  logic [DATA_W-1:0]   w_main_data_nxt;
  logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
  logic [DATA_W-1:0]   w_skid_data_nxt;
  logic                w_accept;
  logic                w_consume;

  // Reset is folded in so upstream never sees ready while the stage is being cleared.
  assign in_ready  = (r_state != FULL) && !Bubble && !Reset;
  assign out_valid = (r_state != EMPTY);
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;

  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  always_comb begin
    unique case (r_state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;

    if (Bubble) begin
      // Flush wins over any handshake this edge; in_ready is already low.
      w_state_nxt     = EMPTY;
      w_main_ctrl_nxt = BUBBLE_CTRL;
      w_main_data_nxt = '0;
      w_skid_ctrl_nxt = '0;
      w_skid_data_nxt = '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt     = ONE;
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end
        end
        ONE: begin
          if (w_accept && w_consume) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else if (w_accept) begin
            // Downstream stalled: park the newer entry behind main.
            w_state_nxt     = FULL;
            w_skid_ctrl_nxt = in_ctrl;
            w_skid_data_nxt = in_data;
          end else if (w_consume) begin
            w_state_nxt     = EMPTY;
            w_main_ctrl_nxt = BUBBLE_CTRL;
            w_main_data_nxt = '0;
          end
        end
        FULL: begin
          if (w_consume) begin
            w_state_nxt     = ONE;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
          end
        end
        default: begin
          w_state_nxt     = EMPTY;
          w_main_ctrl_nxt = BUBBLE_CTRL;
          w_main_data_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(negedge clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= EMPTY;
      r_main_ctrl <= BUBBLE_CTRL;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector bench for pipe_stage_reg.
// Inputs change just after the rising edge; the DUT updates on the falling edge.
// Outputs are sampled 1ns after the falling edge, in_ready just before it.
module tb_pipe_stage_reg;

  localparam int CW = 16;
  localparam int DW = 117;

  logic          clk;
  logic          Reset;
  logic          Bubble;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int n_tests;
  int n_fail;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_CTRL(16'h0000)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Bubble    (Bubble),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Distinct, wide data pattern per ctrl value so data mix-ups are visible.
  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    logic [31:0] lo;
    lo = 32'hDEAD_BEEF ^ {c, c};
    return {c, 5'b10101, lo, 48'hA5A5_0F0F_3C3C, c};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_vld, input logic [1:0] e_occ,
                          input logic [CW-1:0] e_ctrl);
    logic [DW-1:0] e_dat;
    e_dat = e_vld ? mk_data(e_ctrl) : '0;
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(e_vld));
    chk({tag, ".occupancy"}, 128'(occupancy), 128'(e_occ));
    chk({tag, ".out_ctrl"},  128'(out_ctrl),  128'(e_ctrl));
    chk({tag, ".out_data"},  128'(out_data),  128'(e_dat));
  endtask

  typedef struct {
    logic          v;
    logic          r;
    logic          b;
    logic [CW-1:0] c;
    logic          e_rdy;   // in_ready before the edge
    logic          e_vld;   // after the edge
    logic [1:0]    e_occ;
    logic [CW-1:0] e_ctrl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, r, b, input logic [CW-1:0] c,
                              input logic e_rdy, e_vld, input logic [1:0] e_occ,
                              input logic [CW-1:0] e_ctrl);
    vec_t t;
    t.v = v; t.r = r; t.b = b; t.c = c;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_occ = e_occ; t.e_ctrl = e_ctrl;
    tbl.push_back(t);
  endfunction

  task automatic drive(input logic v, r, b, input logic [CW-1:0] c);
    in_valid  = v;
    out_ready = r;
    Bubble    = b;
    in_ctrl   = c;
    in_data   = mk_data(c);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0);

    // Streaming: one entry per cycle, each visible one edge after its accept.
    for (int i = 1; i <= 8; i++)
      add(1, 1, 0, 16'(i), 1, 1, 2'd1, 16'(i));
    add(0, 1, 0, 16'h0, 1, 0, 2'd0, 16'h0);
    // Backpressure fills the skid, then drains in order.
    add(1, 0, 0, 16'hA, 1, 1, 2'd1, 16'hA);
    add(1, 0, 0, 16'hB, 1, 1, 2'd2, 16'hA);
    add(1, 0, 0, 16'h7, 0, 1, 2'd2, 16'hA);   // no accept while full
    add(0, 1, 0, 16'h0, 0, 1, 2'd1, 16'hB);
    add(0, 1, 0, 16'h0, 1, 0, 2'd0, 16'h0);
    // Simultaneous accept and consume in ONE, then consume only.
    add(1, 0, 0, 16'h3, 1, 1, 2'd1, 16'h3);
    add(1, 1, 0, 16'h4, 1, 1, 2'd1, 16'h4);
    add(0, 1, 0, 16'h0, 1, 0, 2'd0, 16'h0);
    // Flush from FULL with a pending upstream entry.
    add(1, 0, 0, 16'h5, 1, 1, 2'd1, 16'h5);
    add(1, 0, 0, 16'h6, 1, 1, 2'd2, 16'h5);
    add(1, 0, 1, 16'hC, 0, 0, 2'd0, 16'h0);
    add(0, 1, 0, 16'h0, 1, 0, 2'd0, 16'h0);   // 0xC must not appear
    // Flush in ONE with consume and accept both requested.
    add(1, 0, 0, 16'h11, 1, 1, 2'd1, 16'h11);
    add(1, 1, 1, 16'h12, 0, 0, 2'd0, 16'h0);

    // Reset state, checked asynchronously with clk running.
    #2;
    chk("rst.in_ready", 128'(in_ready), 128'(0));
    chk_outs("rst", 1'b0, 2'd0, 16'h0);
    @(posedge clk); #1;
    Reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i].v, tbl[i].r, tbl[i].b, tbl[i].c);
      #1;
      chk($sformatf("v%0d.in_ready", i), 128'(in_ready), 128'(tbl[i].e_rdy));
      @(negedge clk); #1;
      chk_outs($sformatf("v%0d", i), tbl[i].e_vld, tbl[i].e_occ, tbl[i].e_ctrl);
    end

    // Asynchronous reset while FULL: cleared before any clock edge.
    @(posedge clk); #1; drive(1, 0, 0, 16'h1234);
    @(negedge clk); #1;
    @(posedge clk); #1; drive(1, 0, 0, 16'h5678);
    @(negedge clk); #1;
    chk_outs("full_pre_rst", 1'b1, 2'd2, 16'h1234);
    @(posedge clk); #1;
    drive(0, 0, 0, 16'h0);
    Reset = 1'b1;
    #1;
    chk("midrst.in_ready", 128'(in_ready), 128'(0));
    chk_outs("midrst", 1'b0, 2'd0, 16'h0);
    @(negedge clk); #1;
    chk_outs("midrst_hold", 1'b0, 2'd0, 16'h0);
    @(posedge clk); #1;
    Reset = 1'b0;
    // First edge after reset behaves as EMPTY; the old skid entry never returns.
    drive(1, 0, 0, 16'h9);
    #1;
    chk("postrst.in_ready", 128'(in_ready), 128'(1));
    @(negedge clk); #1;
    chk_outs("postrst_acc", 1'b1, 2'd1, 16'h9);
    @(posedge clk); #1; drive(0, 1, 0, 16'h0);
    @(negedge clk); #1;
    chk_outs("postrst_drain", 1'b0, 2'd0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything this long is a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 16: width of the control field (RegWrite, MemRead, ALUOp, ...).
REQ-002 SHALL have parameter DATA_W, default 117: width of the data field (operands, immediate, sign-extended value).
REQ-003 SHALL have parameter BUBBLE_CTRL, default 0 (CTRL_W bits): control value presented while the stage holds no valid entry.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, as listed below.
REQ-005 Port: clk  in  1  single clock; all state updates occur on the falling edge.
REQ-006 Port: Reset  in  1  asynchronous, active-high reset.
REQ-007 Port: Bubble  in  1  synchronous flush: discard all held entries.
REQ-008 Port: in_valid  in  1  upstream entry present.
REQ-009 Port: in_ready  out  1  stage can accept an entry.
REQ-010 Port: in_ctrl  in  CTRL_W  upstream control field.
REQ-011 Port: in_data  in  DATA_W  upstream data field.
REQ-012 Port: out_valid  out  1  out_ctrl/out_data hold a valid entry.
REQ-013 Port: out_ready  in  1  downstream accepts the entry.
REQ-014 Port: out_ctrl  out  CTRL_W  registered control field.
REQ-015 Port: out_data  out  DATA_W  registered data field.
REQ-016 Port: occupancy  out  2  number of held entries: 0, 1 or 2.

Function
REQ-017 Storage: main register (drives out_*) plus one skid register; states EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
REQ-018 Accept = in_valid & in_ready; consume = out_valid & out_ready; both are sampled at the falling edge of clk.
REQ-019 in_ready SHALL be combinational: 1 when state != FULL and Bubble = 0; in_ready SHALL NOT depend on out_ready.
REQ-020 out_valid SHALL be 1 in ONE and FULL, and 0 in EMPTY; occupancy SHALL equal the entry count.
REQ-021 EMPTY transitions:
  - accept -> ONE, main <= in.
  - otherwise -> hold.
REQ-022 ONE transitions:
  - accept & consume -> ONE, main <= in.
  - accept & ~consume -> FULL, skid <= in, main unchanged.
  - ~accept & consume -> EMPTY.
  - otherwise -> hold.
REQ-023 FULL transitions:
  - consume -> ONE, main <= skid.
  - otherwise -> hold.
  - No accept is possible in FULL.
REQ-024 Ordering SHALL be strict FIFO; no entry SHALL be lost or duplicated.
REQ-025 Whenever the state becomes EMPTY: out_ctrl <= BUBBLE_CTRL and out_data <= 0.
REQ-026 Bubble = 1 at an edge:
  - state -> EMPTY; main and skid are discarded.
  - out_ctrl <= BUBBLE_CTRL, out_data <= 0.
  - No entry is accepted that cycle.
  - Bubble has priority over accept and consume.
REQ-027 Latency: an entry accepted into EMPTY, or into ONE with simultaneous consume, SHALL appear on out_* 1 edge later.
REQ-028 Throughput: 1 entry per cycle SHALL be sustained while out_ready = 1.
REQ-029 Widths: fields are passed bit-exact; no arithmetic, truncation or extension.

Reset
REQ-030 Reset = 1 SHALL immediately, regardless of clk:
  - force state EMPTY;
  - out_valid = 0, occupancy = 0;
  - out_ctrl = BUBBLE_CTRL, out_data = 0;
  - skid register = 0.
REQ-031 While Reset = 1, in_ready SHALL be 0.
REQ-032 After Reset deasserts, the first falling edge SHALL behave as EMPTY.
REQ-033 Reset asserted mid-operation, in any state, SHALL discard all entries, identically to REQ-030.

Verification
REQ-034 Reset pulse mid-stream with FULL state (ctrl 0x1234, 0x5678 held) -> out_valid = 0, occupancy = 0, out_ctrl = 0x0000, out_data = 0 before the next clk edge.
REQ-035 Streaming with out_ready = 1, in_valid = 1 for 8 cycles, in_ctrl = 1..8 -> out_ctrl = 1..8 on consecutive edges, each one edge after its accept; occupancy stays 1; in_ready stays 1.
REQ-036 Backpressure: out_ready = 0, push ctrl 0xA, 0xB ->
  - occupancy 2, in_ready = 0, out_ctrl = 0xA.
  - Raise out_ready -> out_ctrl = 0xB next edge, in_ready returns to 1.
REQ-037 Bubble in FULL with in_valid = 1 and in_ctrl = 0xC -> next edge:
  - occupancy 0, out_valid = 0, out_ctrl = BUBBLE_CTRL.
  - 0xC is not accepted (in_ready = 0 during Bubble).
REQ-038 ONE state, simultaneous accept and consume (main 0x3, in 0x4) -> out_ctrl = 0x4, occupancy 1; ONE with consume only -> EMPTY, out_ctrl = BUBBLE_CTRL, out_data = 0.
